// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
package regbank_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        STALL = 2'd2
    } state_e;

    // Width of a requester index.
    function automatic int calc_idw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regbank_wr_arbiter_rr_pick.sv
// Round-robin picker: rotate the valid vector so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the result back.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any_valid
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    pos;
    logic [IDW:0]      abs_idx;
    logic              found;

    // Rotate, priority encode, rotate back.
    always_comb begin
        dbl   = {valid, valid} >> ptr;
        rot   = dbl[NREQ-1:0];
        pos   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                pos   = IDW'(j);
                found = 1'b1;
            end
        end
        abs_idx = {1'b0, pos} + {1'b0, ptr};
        if (abs_idx >= (IDW+1)'(NREQ)) begin
            abs_idx = abs_idx - (IDW+1)'(NREQ);
        end
        idx       = abs_idx[IDW-1:0];
        grant     = '0;
        if (found) begin
            grant[idx] = 1'b1;
        end
        any_valid = found;
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Write-port arbiter for the register bank: round-robin pick among NREQ
// requesters, one registered write per cycle, honours bank back-pressure.
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*AW-1:0]          req_addr,
    input  logic [NREQ*DW-1:0]          req_data,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        wr_stall,
    output logic                        wr_en,
    output logic [AW-1:0]               wr_addr,
    output logic [DW-1:0]               wr_data,
    output logic [calc_idw(NREQ)-1:0]   grant_id
);

    localparam int IDW = calc_idw(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IDW-1:0]  pick_idx;
    logic            any_valid;
    logic            out_free;
    logic            xfer;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_onehot),
        .idx       (pick_idx),
        .any_valid (any_valid)
    );

    // Accept a request when the output register is empty or draining this cycle.
    always_comb begin
        out_free  = (state_q == IDLE) || !wr_stall;
        xfer      = any_valid && out_free && rst_n;
        req_ready = xfer ? pick_onehot : '0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = xfer ? WRITE : IDLE;
            WRITE, STALL: begin
                if (wr_stall) begin
                    state_d = STALL;
                end else begin
                    state_d = xfer ? WRITE : IDLE;
                end
            end
            default:      state_d = IDLE;
        endcase
    end

    // Output decode: a write is presented in WRITE and held in STALL.
    always_comb begin
        wr_en    = (state_q != IDLE);
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
        grant_id = grant_id_q;
    end

    // Load the winner into the output register and advance the pointer past it.
    always_comb begin
        ptr_d      = ptr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (xfer) begin
            ptr_d      = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
            wr_addr_d  = req_addr[pick_idx*AW +: AW];
            wr_data_d  = req_data[pick_idx*DW +: DW];
            grant_id_d = pick_idx;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

endmodule
